bcd_scan_mux: RTL and testbench

BCD_SCAN_MUX -- requirements
Module: bcd_scan_mux

---
 rtl/bcd_scan_mux.sv | 70 +++++++
 tb/tb_bcd_scan_mux.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/bcd_scan_mux.sv
// Four-digit multiplexed BCD display scanner with frame-synchronous display update.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit0 always lit).
module bcd_scan_mux #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] digits_in,
    output logic [3:0]  bcd_out,
    output logic [3:0]  dig_sel,
    output logic        err
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] presc;
    logic [1:0]       idx;
    logic [15:0]      shadow;
    logic [15:0]      display;
    logic             tick;

    function automatic logic has_non_bcd(input logic [15:0] d);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (d[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    assign tick = (presc == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc   <= '0;
            idx     <= 2'd0;
            shadow  <= 16'h0000;
            display <= 16'h0000;
            err     <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + CNT_W'(1);
            if (tick) idx <= idx + 2'd1;
            if (load) begin
                shadow <= digits_in;
                err    <= has_non_bcd(digits_in);
            end
            // Display only refreshes at the frame boundary so a frame never mixes two values
            if (tick && idx == 2'd3) display <= shadow;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] lead_zero;
    assign lead_zero[3] = (display[15:12] == 4'd0);
    assign lead_zero[2] = lead_zero[3] && (display[11:8] == 4'd0);
    assign lead_zero[1] = lead_zero[2] && (display[7:4] == 4'd0);
    assign lead_zero[0] = 1'b0;
`endif

    always_comb begin
        bcd_out = display[{idx, 2'b00} +: 4];
        dig_sel = 4'b0001 << idx;
`ifdef LEADING_ZERO_BLANK_EN
        if (lead_zero[idx]) dig_sel = 4'b0000;
`endif
    end

endmodule

// File: tb/tb_bcd_scan_mux.sv
// Directed bench for bcd_scan_mux at SCAN_DIV=4; honours LEADING_ZERO_BLANK_EN if defined.
module tb_bcd_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  bcd_out;
    logic [3:0]  dig_sel;
    logic        err;

    int checks = 0;
    int errors = 0;
    int k = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic BLANK_EN = 1'b1;
`else
    localparam logic BLANK_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] din;
        logic        exp_err;
        logic [3:0]  blank_mask;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    bcd_scan_mux #(.SCAN_DIV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .digits_in (digits_in),
        .bcd_out   (bcd_out),
        .dig_sel   (dig_sel),
        .err       (err)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at k=%0d: got %h expected %h", name, k, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic go_phase(input int ph);
        while ((k % 16) != ph) step(1);
    endtask

    function automatic logic [3:0] bm(input logic [3:0] m);
        return BLANK_EN ? m : 4'b0000;
    endfunction

    // k counts cycles since reset release: slot index is (k/4)%4, frames start at k%16==0
    task automatic check_cycles(input logic [15:0] disp, input logic [3:0] mask,
                                input logic exp_err, input int n);
        int idx;
        logic [3:0] exp_sel;
        for (int i = 0; i < n; i++) begin
            idx = (k / 4) % 4;
            exp_sel = mask[idx] ? 4'b0000 : (4'b0001 << idx);
            chk("dig_sel", {12'h0, dig_sel}, {12'h0, exp_sel});
            chk("bcd_out", {12'h0, bcd_out}, {12'h0, disp[idx*4 +: 4]});
            chk("err", {15'h0, err}, {15'h0, exp_err});
            step(1);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        digits_in = v;
        step(1);
        load = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h1234, 1'b0, 4'b0000};
        vecs[1] = '{16'h12A4, 1'b1, 4'b0000};
        vecs[2] = '{16'h0005, 1'b0, 4'b1110};
        vecs[3] = '{16'h0070, 1'b0, 4'b1100};
        vecs[4] = '{16'h0000, 1'b0, 4'b1110};
        vecs[5] = '{16'h0305, 1'b0, 4'b1000};
        vecs[6] = '{16'hF0F0, 1'b1, 4'b0000};
        vecs[7] = '{16'h9999, 1'b0, 4'b0000};

        rst_n = 1'b0;
        load = 1'b0;
        digits_in = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        chk("reset_dig_sel", {12'h0, dig_sel}, 16'h0001);
        chk("reset_bcd_out", {12'h0, bcd_out}, 16'h0000);
        chk("reset_err", {15'h0, err}, 16'h0000);
        step(1);

        for (int v = 0; v < 8; v++) begin
            go_phase(5);
            do_load(vecs[v].din);
            chk("err_after_load", {15'h0, err}, {15'h0, vecs[v].exp_err});
            go_phase(0);
            check_cycles(vecs[v].din, bm(vecs[v].blank_mask), vecs[v].exp_err, 16);
        end

        // Mid-frame load must not tear the frame in progress
        go_phase(5);
        do_load(16'h1234);
        go_phase(0);
        check_cycles(16'h1234, 4'b0000, 1'b0, 5);
        do_load(16'h5678);
        check_cycles(16'h1234, 4'b0000, 1'b0, 10);
        check_cycles(16'h5678, 4'b0000, 1'b0, 16);

        // Load on the frame-boundary tick lands one frame later
        go_phase(15);
        do_load(16'h9999);
        check_cycles(16'h5678, 4'b0000, 1'b0, 16);
        check_cycles(16'h9999, 4'b0000, 1'b0, 16);

        // Only the last of several loads in a frame is shown
        go_phase(2);
        do_load(16'h1111);
        go_phase(6);
        do_load(16'h2222);
        go_phase(0);
        check_cycles(16'h2222, 4'b0000, 1'b0, 16);

        // Mid-frame reset during slot 2 drops the pending value and restarts timing
        go_phase(3);
        do_load(16'hFFFF);
        chk("err_ffff", {15'h0, err}, 16'h0001);
        go_phase(9);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        k = 0;
        check_cycles(16'h0000, bm(4'b1110), 1'b0, 16);
        check_cycles(16'h0000, bm(4'b1110), 1'b0, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
